sys_periph_responder: RTL and testbench



---
 rtl/sys_periph_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_sys_periph_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_periph_responder.sv
// sys_periph_responder: memory-mapped responder for the pipeline's sys-bus
// strobes. Hosts a 64-bit cycle counter, a down-counting timer with
// interrupt, RX/TX mailbox FIFOs and a scratch register.
module sys_periph_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sys_r,
  input  logic [31:0] sys_r_addr,
  output logic [31:0] sys_r_line,
  input  logic        sys_w,
  input  logic [31:0] sys_w_addr,
  input  logic [31:0] sys_w_line,
  output logic        irq,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] IDX_CYCLE_LO   = 3'd0;
  localparam logic [2:0] IDX_CYCLE_HI   = 3'd1;
  localparam logic [2:0] IDX_TMR_CNT    = 3'd2;
  localparam logic [2:0] IDX_TMR_RELOAD = 3'd3;
  localparam logic [2:0] IDX_CTRL       = 3'd4;
  localparam logic [2:0] IDX_STATUS     = 3'd5;
  localparam logic [2:0] IDX_FIFO       = 3'd6;
  localparam logic [2:0] IDX_SCRATCH    = 3'd7;

  // Architectural state
  logic [63:0]   cycle_q, cycle_d;
  logic [DW-1:0] hi_snap_q, hi_snap_d;
  logic [DW-1:0] tmr_cnt_q, tmr_cnt_d;
  logic [DW-1:0] tmr_reload_q, tmr_reload_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          tmr_flag_q, tmr_flag_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          irq_q, irq_d;
  logic [DW-1:0] scratch_q, scratch_d;

  // FIFO storage and bookkeeping
  logic [DW-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DW-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d, rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d, tx_wr_ptr_q, tx_wr_ptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

  // Decode and event strobes
  logic          rd_hit, wr_hit;
  logic [2:0]    rd_idx, wr_idx;
  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          rx_push, rx_pop, tx_wr, tx_push, tx_pop;
  logic          status_wr, tmr_flag_set, tx_ovf_set;
  logic [DW-1:0] status_word;

  assign rd_hit = sys_r && (sys_r_addr[31:3] == BASE_ADDR[31:3]);
  assign wr_hit = sys_w && (sys_w_addr[31:3] == BASE_ADDR[31:3]);
  assign rd_idx = sys_r_addr[2:0];
  assign wr_idx = sys_w_addr[2:0];

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));

  assign in_ready  = !rx_full;
  assign out_valid = !tx_empty;
  assign out_data  = tx_mem_q[tx_rd_ptr_q];
  assign irq       = irq_q;

  // Per-cycle events; all judged on pre-edge state
  always_comb begin
    rx_push    = in_valid && !rx_full;
    rx_pop     = rd_hit && (rd_idx == IDX_FIFO) && !rx_empty;
    tx_wr      = wr_hit && (wr_idx == IDX_FIFO);
    tx_push    = tx_wr && !tx_full;
    tx_pop     = !tx_empty && out_ready;
    tx_ovf_set = tx_wr && tx_full;
    status_wr  = wr_hit && (wr_idx == IDX_STATUS);
  end

  // Status word assembly
  always_comb begin
    status_word        = '0;
    status_word[0]     = tmr_flag_q;
    status_word[1]     = rx_empty;
    status_word[2]     = rx_full;
    status_word[3]     = tx_empty;
    status_word[4]     = tx_full;
    status_word[5]     = tx_ovf_q;
    status_word[11:8]  = 4'(rx_cnt_q);
    status_word[15:12] = 4'(tx_cnt_q);
  end

  // Read mux: combinational from the upstream-registered strobe and address
  always_comb begin
    sys_r_line = '0;
    if (rd_hit) begin
      case (rd_idx)
        IDX_CYCLE_LO:   sys_r_line = cycle_q[31:0];
        IDX_CYCLE_HI:   sys_r_line = hi_snap_q;
        IDX_TMR_CNT:    sys_r_line = tmr_cnt_q;
        IDX_TMR_RELOAD: sys_r_line = tmr_reload_q;
        IDX_CTRL:       sys_r_line = DW'(ctrl_q);
        IDX_STATUS:     sys_r_line = status_word;
        IDX_FIFO:       sys_r_line = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
        IDX_SCRATCH:    sys_r_line = scratch_q;
        default:        sys_r_line = '0;
      endcase
    end
  end

  // Cycle counter, high-word snapshot and plain CPU registers
  always_comb begin
    cycle_d      = cycle_q + 64'd1;
    hi_snap_d    = hi_snap_q;
    tmr_reload_d = tmr_reload_q;
    ctrl_d       = ctrl_q;
    scratch_d    = scratch_q;
    if (rd_hit && (rd_idx == IDX_CYCLE_LO)) begin
      hi_snap_d = cycle_q[63:32];
    end
    if (wr_hit) begin
      case (wr_idx)
        IDX_TMR_RELOAD: tmr_reload_d = sys_w_line;
        IDX_CTRL:       ctrl_d       = sys_w_line[2:0];
        IDX_SCRATCH:    scratch_d    = sys_w_line;
        default:        ;
      endcase
    end
  end

  // Timer step, reload, CPU override and sticky flags (set beats W1C)
  always_comb begin
    tmr_cnt_d    = tmr_cnt_q;
    tmr_flag_set = 1'b0;
    if (ctrl_q[0] && (tmr_cnt_q != '0)) begin
      if (tmr_cnt_q == DW'(1)) begin
        tmr_flag_set = 1'b1;
        tmr_cnt_d    = ctrl_q[1] ? tmr_reload_q : '0;
      end else begin
        tmr_cnt_d = tmr_cnt_q - DW'(1);
      end
    end
    if (wr_hit && (wr_idx == IDX_TMR_CNT)) begin
      tmr_cnt_d = sys_w_line;
    end
    tmr_flag_d = tmr_flag_set || (tmr_flag_q && !(status_wr && sys_w_line[0]));
    tx_ovf_d   = tx_ovf_set || (tx_ovf_q && !(status_wr && sys_w_line[5]));
    irq_d      = ctrl_d[2] && tmr_flag_d;
  end

  // FIFO pointers and occupancy
  always_comb begin
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q      <= '0;
      hi_snap_q    <= '0;
      tmr_cnt_q    <= '0;
      tmr_reload_q <= '0;
      ctrl_q       <= '0;
      tmr_flag_q   <= 1'b0;
      tx_ovf_q     <= 1'b0;
      irq_q        <= 1'b0;
      scratch_q    <= '0;
      rx_rd_ptr_q  <= '0;
      rx_wr_ptr_q  <= '0;
      rx_cnt_q     <= '0;
      tx_rd_ptr_q  <= '0;
      tx_wr_ptr_q  <= '0;
      tx_cnt_q     <= '0;
    end else begin
      cycle_q      <= cycle_d;
      hi_snap_q    <= hi_snap_d;
      tmr_cnt_q    <= tmr_cnt_d;
      tmr_reload_q <= tmr_reload_d;
      ctrl_q       <= ctrl_d;
      tmr_flag_q   <= tmr_flag_d;
      tx_ovf_q     <= tx_ovf_d;
      irq_q        <= irq_d;
      scratch_q    <= scratch_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_cnt_q     <= tx_cnt_d;
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= in_data;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= sys_w_line;
  end

endmodule

// File: tb/tb_sys_periph_responder.sv
// Bench for sys_periph_responder: directed scenarios plus a randomized
// FIFO/scratch phase checked against a queue-based reference model.
module tb_sys_periph_responder;

  localparam logic [31:0] TB_BASE = 32'h4000_0010;
  localparam int          DEPTH   = 8;

  localparam logic [2:0] R_LO = 3'd0, R_HI = 3'd1, R_CNT = 3'd2, R_RLD = 3'd3;
  localparam logic [2:0] R_CTRL = 3'd4, R_STAT = 3'd5, R_FIFO = 3'd6, R_SCR = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_r, sys_w;
  logic [31:0] sys_r_addr, sys_r_line, sys_w_addr, sys_w_line;
  logic        irq;
  logic [31:0] in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;

  sys_periph_responder #(.BASE_ADDR(TB_BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .sys_r(sys_r), .sys_r_addr(sys_r_addr), .sys_r_line(sys_r_line),
    .sys_w(sys_w), .sys_w_addr(sys_w_addr), .sys_w_line(sys_w_line),
    .irq(irq),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] cyc = '0;

  // Reference model state
  logic [31:0] rx_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] scratch_m;
  logic        ovf_m, flag_m;
  logic [31:0] cnt_m;

  task automatic tick();
    @(posedge clk);
    cyc = rst ? 64'd0 : cyc + 64'd1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    sys_w = 1'b1; sys_w_addr = TB_BASE | 32'(idx); sys_w_line = d;
    tick();
    sys_w = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    sys_r = 1'b1; sys_r_addr = TB_BASE | 32'(idx);
    #1;
    chk(tag, 64'(sys_r_line), 64'(exp));
    tick();
    sys_r = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = flag_m;
    s[1]     = (rx_q.size() == 0);
    s[2]     = (rx_q.size() == DEPTH);
    s[3]     = (tx_q.size() == 0);
    s[4]     = (tx_q.size() == DEPTH);
    s[5]     = ovf_m;
    s[11:8]  = 4'(rx_q.size());
    s[15:12] = 4'(tx_q.size());
    return s;
  endfunction

  int          rsel, wsel;
  logic [31:0] wd, exp_rd;
  logic        do_rx_push, do_rx_pop, do_tx_pop, tx_full_pre, set_m;

  initial begin
    rst = 1'b1; sys_r = 1'b0; sys_w = 1'b0;
    sys_r_addr = '0; sys_w_addr = '0; sys_w_line = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    scratch_m = '0; ovf_m = 1'b0; flag_m = 1'b0; cnt_m = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_r_line", 64'(sys_r_line), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rd_chk("rst_status", R_STAT, 32'h0000_000A);

    // Cycle counter after a hold
    repeat (100) tick();
    rd_chk("cycle_lo", R_LO, cyc[31:0]);
    rd_chk("cycle_hi", R_HI, 32'h0);

    // Timer one-shot with interrupt
    wr(R_CNT, 32'd3);
    wr(R_CTRL, 32'd5);
    chk("oneshot_irq_c0", 64'(irq), 64'd0);
    tick(); chk("oneshot_irq_c1", 64'(irq), 64'd0);
    tick(); chk("oneshot_irq_c2", 64'(irq), 64'd0);
    tick(); chk("oneshot_irq_c3", 64'(irq), 64'd1);
    rd_chk("oneshot_cnt", R_CNT, 32'd0);
    wr(R_STAT, 32'd1);
    chk("oneshot_irq_clr", 64'(irq), 64'd0);
    repeat (5) tick();
    chk("oneshot_irq_idle", 64'(irq), 64'd0);
    rd_chk("oneshot_status", R_STAT, 32'h0000_000A);
    wr(R_CTRL, 32'd0);

    // Timer auto-reload; W1C each cycle, a same-cycle set must win
    wr(R_RLD, 32'd2);
    wr(R_CNT, 32'd2);
    wr(R_CTRL, 32'd7);
    rd_chk("ctrl_rb", R_CTRL, 32'd7);
    cnt_m = 32'd1; flag_m = 1'b0;   // the readback cycle stepped 2 -> 1
    for (int k = 0; k < 6; k++) begin
      sys_r = 1'b1; sys_r_addr = TB_BASE | 32'(R_CNT);
      sys_w = 1'b1; sys_w_addr = TB_BASE | 32'(R_STAT); sys_w_line = 32'd1;
      #1;
      chk("reload_cnt", 64'(sys_r_line), 64'(cnt_m));
      chk("reload_irq", 64'(irq), 64'(flag_m));
      tick();
      set_m  = (cnt_m == 32'd1);
      cnt_m  = set_m ? 32'd2 : cnt_m - 32'd1;
      flag_m = set_m;
    end
    sys_r = 1'b0; sys_w = 1'b0;
    wr(R_CTRL, 32'd0);
    wr(R_STAT, 32'd1);
    flag_m = 1'b0;
    rd_chk("reload_status", R_STAT, exp_status());

    // RX FIFO fill past full, then drain past empty
    for (int i = 0; i < 9; i++) begin
      in_data = 32'h100 + 32'(i); in_valid = 1'b1;
      chk("rx_in_ready", 64'(in_ready), 64'(rx_q.size() < DEPTH));
      tick();
      if (rx_q.size() < DEPTH) rx_q.push_back(32'h100 + 32'(i));
    end
    in_valid = 1'b0;
    rd_chk("rx_full_status", R_STAT, exp_status());
    for (int i = 0; i < 9; i++) begin
      exp_rd = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
      rd_chk("rx_pop_data", R_FIFO, exp_rd);
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    rd_chk("rx_empty_status", R_STAT, exp_status());

    // TX overflow, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (tx_q.size() == DEPTH) ovf_m = 1'b1;
      else tx_q.push_back(32'h200 + 32'(i));
      wr(R_FIFO, 32'h200 + 32'(i));
    end
    rd_chk("tx_ovf_status", R_STAT, exp_status());
    chk("tx_head_stable", 64'(out_data), 64'h200);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("tx_out_valid", 64'(out_valid), 64'(tx_q.size() > 0));
      if (tx_q.size() > 0) chk("tx_out_data", 64'(out_data), 64'(tx_q[0]));
      tick();
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    out_ready = 1'b0;
    wr(R_STAT, 32'h20);
    ovf_m = 1'b0;
    rd_chk("tx_ovf_clr", R_STAT, exp_status());

    // Same-cycle read and write of SCRATCH
    wr(R_SCR, 32'hA5);
    sys_r = 1'b1; sys_r_addr = TB_BASE | 32'(R_SCR);
    sys_w = 1'b1; sys_w_addr = TB_BASE | 32'(R_SCR); sys_w_line = 32'h5A;
    #1;
    chk("rw_same_old", 64'(sys_r_line), 64'hA5);
    tick();
    sys_r = 1'b0; sys_w = 1'b0;
    rd_chk("rw_same_new", R_SCR, 32'h5A);
    scratch_m = 32'h5A;

    // Address decode misses and idle strobe
    sys_r = 1'b1; sys_r_addr = TB_BASE + 32'h8 + 32'(R_SCR);
    #1; chk("miss_read", 64'(sys_r_line), 64'd0);
    sys_r = 1'b0; sys_r_addr = TB_BASE | 32'(R_SCR);
    #1; chk("idle_read", 64'(sys_r_line), 64'd0);
    sys_w = 1'b1; sys_w_addr = (TB_BASE | 32'(R_SCR)) ^ 32'h8000_0000; sys_w_line = 32'hFFFF;
    tick();
    sys_w = 1'b0;
    rd_chk("miss_write", R_SCR, scratch_m);

    // Randomized FIFO/scratch/status traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      rsel = int'($urandom_range(0, 4));
      wsel = int'($urandom_range(0, 3));
      wd   = $urandom;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) == 0);
      sys_r = (rsel != 0);
      case (rsel)
        1: sys_r_addr = TB_BASE | 32'(R_FIFO);
        2: sys_r_addr = TB_BASE | 32'(R_STAT);
        3: sys_r_addr = TB_BASE | 32'(R_SCR);
        default: sys_r_addr = TB_BASE | 32'(R_LO);
      endcase
      sys_w = (wsel != 0); sys_w_line = wd;
      case (wsel)
        1: sys_w_addr = TB_BASE | 32'(R_FIFO);
        2: sys_w_addr = TB_BASE | 32'(R_SCR);
        default: sys_w_addr = TB_BASE | 32'(R_STAT);
      endcase
      case (rsel)
        0: exp_rd = 32'h0;
        1: exp_rd = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
        2: exp_rd = exp_status();
        3: exp_rd = scratch_m;
        default: exp_rd = cyc[31:0];
      endcase
      #1;
      chk("rnd_read", 64'(sys_r_line), 64'(exp_rd));
      chk("rnd_in_ready", 64'(in_ready), 64'(rx_q.size() < DEPTH));
      chk("rnd_out_valid", 64'(out_valid), 64'(tx_q.size() > 0));
      if (tx_q.size() > 0) chk("rnd_out_data", 64'(out_data), 64'(tx_q[0]));
      chk("rnd_irq", 64'(irq), 64'd0);
      do_rx_push  = in_valid && (rx_q.size() < DEPTH);
      do_rx_pop   = (rsel == 1) && (rx_q.size() > 0);
      do_tx_pop   = out_ready && (tx_q.size() > 0);
      tx_full_pre = (tx_q.size() == DEPTH);
      tick();
      if (do_rx_pop) void'(rx_q.pop_front());
      if (do_rx_push) rx_q.push_back(in_data);
      if (do_tx_pop) void'(tx_q.pop_front());
      if (wsel == 1) begin
        if (tx_full_pre) ovf_m = 1'b1;
        else tx_q.push_back(wd);
      end
      if (wsel == 2) scratch_m = wd;
      if (wsel == 3 && wd[5]) ovf_m = 1'b0;
    end
    sys_r = 1'b0; sys_w = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rd_chk("rnd_final_status", R_STAT, exp_status());

    // Reset mid-operation with data queued and an interrupt pending
    in_valid = 1'b1; in_data = 32'hDEAD;
    tick(); tick();
    in_valid = 1'b0;
    wr(R_FIFO, 32'hBEEF);
    wr(R_CNT, 32'd1);
    wr(R_CTRL, 32'd7);
    tick();
    chk("pre_rst_irq", 64'(irq), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_q.delete(); tx_q.delete(); ovf_m = 1'b0; flag_m = 1'b0; scratch_m = '0;
    chk("mid_rst_irq", 64'(irq), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    rd_chk("mid_rst_status", R_STAT, 32'h0000_000A);
    rd_chk("mid_rst_ctrl", R_CTRL, 32'h0);
    rd_chk("mid_rst_scratch", R_SCR, scratch_m);
    rd_chk("mid_rst_fifo", R_FIFO, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
